// File: rtl/conv_pkg.sv
// Shared constants, window geometry helpers and FSM state type for the
// 3x3 convolution PE sequencer.
package conv_pkg;

    localparam int KSIZE        = 3;
    localparam int DEF_CH       = 3;
    localparam int MACS_PER_WIN = DEF_CH * KSIZE * KSIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic int OUT_W(input int img_w);
        return img_w - KSIZE + 1;
    endfunction

    function automatic int OUT_H(input int img_h);
        return img_h - KSIZE + 1;
    endfunction

    function automatic int NUM_WIN(input int img_w, input int img_h);
        return OUT_W(img_w) * OUT_H(img_h);
    endfunction

endpackage

// File: rtl/conv_pe_seq_if.sv
// Buffer, PE and control signals between the sequencer (master) and its
// environment (slave: buffers, PE, host).
interface conv_pe_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FM_ADDR_W  = 8,
    parameter int W_ADDR_W   = 5,
    parameter int OUT_ADDR_W = 6
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [FM_ADDR_W-1:0]    fm_addr;
    logic [W_ADDR_W-1:0]     w_addr;
    logic                    pe_en_din;
    logic                    pe_en_win;
    logic                    pe_ready;
    logic [2*DATA_WIDTH-1:0] pe_result;
    logic                    out_we;
    logic [OUT_ADDR_W-1:0]   out_addr;
    logic [2*DATA_WIDTH-1:0] out_data;

    modport master (
        input  start, pe_ready, pe_result,
        output busy, done, rd_en, fm_addr, w_addr, pe_en_din, pe_en_win,
               out_we, out_addr, out_data
    );

    modport slave (
        output start, pe_ready, pe_result,
        input  busy, done, rd_en, fm_addr, w_addr, pe_en_din, pe_en_win,
               out_we, out_addr, out_data
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Slot/window counters and buffer address arithmetic. One step per RUN
// cycle: k walks 0..MACS (MACS is the bubble slot), c/ky/kx shadow k so no
// division is needed, and ox/oy advance on the bubble with ox fastest.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int CH        = 3,
    parameter int FM_ADDR_W = 8,
    parameter int W_ADDR_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_i,
    output logic [FM_ADDR_W-1:0] fm_addr_o,
    output logic [W_ADDR_W-1:0]  w_addr_o,
    output logic                 last_slot_o,
    output logic                 last_window_o
);
    localparam int MACS = CH * KSIZE * KSIZE;
    localparam int OW   = OUT_W(IMG_W);
    localparam int OH   = OUT_H(IMG_H);
    localparam int K_W  = $clog2(MACS + 1);
    localparam int C_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int OX_W = $clog2(IMG_W);
    localparam int OY_W = $clog2(IMG_H);

    logic [K_W-1:0]  k_q;
    logic [C_W-1:0]  c_q;
    logic [1:0]      ky_q;
    logic [1:0]      kx_q;
    logic [OX_W-1:0] ox_q;
    logic [OY_W-1:0] oy_q;

    assign last_slot_o   = (k_q == K_W'(MACS));
    assign last_window_o = (ox_q == OX_W'(OW - 1)) && (oy_q == OY_W'(OH - 1));
    assign w_addr_o      = W_ADDR_W'(k_q);
    assign fm_addr_o     = FM_ADDR_W'(c_q) * FM_ADDR_W'(IMG_H * IMG_W)
                         + (FM_ADDR_W'(oy_q) + FM_ADDR_W'(ky_q)) * FM_ADDR_W'(IMG_W)
                         + FM_ADDR_W'(ox_q) + FM_ADDR_W'(kx_q);

    // Advance the slot counters; on the bubble slot wrap k and move the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q  <= '0;
            c_q  <= '0;
            ky_q <= '0;
            kx_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else if (step_i) begin
            if (last_slot_o) begin
                k_q <= '0;
                if (ox_q == OX_W'(OW - 1)) begin
                    ox_q <= '0;
                    oy_q <= (oy_q == OY_W'(OH - 1)) ? '0 : oy_q + OY_W'(1);
                end else begin
                    ox_q <= ox_q + OX_W'(1);
                end
            end else begin
                k_q <= k_q + K_W'(1);
                if (kx_q == 2'(KSIZE - 1)) begin
                    kx_q <= '0;
                    if (ky_q == 2'(KSIZE - 1)) begin
                        ky_q <= '0;
                        c_q  <= (c_q == C_W'(CH - 1)) ? '0 : c_q + C_W'(1);
                    end else begin
                        ky_q <= ky_q + 2'd1;
                    end
                end else begin
                    kx_q <= kx_q + 2'd1;
                end
            end
        end
    end
endmodule

// File: rtl/conv_pe_seq.sv
// Frame sequencer for one 3x3 multi-channel convolution PE: reads operands
// window by window, keeps the PE enable continuous across windows, and
// writes each PE result to the output buffer in raster order.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing 27 reads + 1 bubble per window
//   DRAIN | reads finished, waiting for the last PE result
//   DONE  | one-cycle done pulse
module conv_pe_seq
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int CH         = 3,
    parameter int FM_ADDR_W  = 8,
    parameter int W_ADDR_W   = 5,
    parameter int OUT_ADDR_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_pe_seq_if.master  bus
);
    localparam int NWIN = NUM_WIN(IMG_W, IMG_H);

    seq_state_e              state_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_en_q;
    logic                    run_q;
    logic                    pe_en_q;
    logic [FM_ADDR_W-1:0]    fm_addr_q;
    logic [W_ADDR_W-1:0]     w_addr_q;
    logic [OUT_ADDR_W-1:0]   out_addr_q;
    logic [OUT_ADDR_W-1:0]   out_addr_d;

    logic                    step;
    logic                    wr_ok;
    logic                    last_result;
    logic                    last_slot;
    logic                    last_window;
    logic [FM_ADDR_W-1:0]    ag_fm_addr;
    logic [W_ADDR_W-1:0]     ag_w_addr;
    logic [2*DATA_WIDTH-1:0] wr_data;

    // Counters step on the accepting start edge (slot 0) and every RUN cycle.
    assign step        = ((state_q == IDLE) && bus.start) || (state_q == RUN);
    assign wr_ok       = bus.pe_ready && ((state_q == RUN) || (state_q == DRAIN));
    assign last_result = (out_addr_q == OUT_ADDR_W'(NWIN - 1));
    assign wr_data     = wr_ok ? bus.pe_result : '0;

    conv_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .CH        (CH),
        .FM_ADDR_W (FM_ADDR_W),
        .W_ADDR_W  (W_ADDR_W)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .step_i        (step),
        .fm_addr_o     (ag_fm_addr),
        .w_addr_o      (ag_w_addr),
        .last_slot_o   (last_slot),
        .last_window_o (last_window)
    );

    // Result counter saturates at the last output pixel.
    always_comb begin
        out_addr_d = out_addr_q;
        if (wr_ok && !last_result) begin
            out_addr_d = out_addr_q + OUT_ADDR_W'(1);
        end
    end

    // Sequencer FSM with registered read strobe, addresses and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            run_q      <= 1'b0;
            pe_en_q    <= 1'b0;
            fm_addr_q  <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
        end else begin
            pe_en_q    <= run_q;
            out_addr_q <= out_addr_d;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        run_q      <= 1'b1;
                        rd_en_q    <= 1'b1;
                        fm_addr_q  <= ag_fm_addr;
                        w_addr_q   <= ag_w_addr;
                        out_addr_q <= '0;
                    end
                end
                RUN: begin
                    run_q <= 1'b1;
                    if (last_slot) begin
                        rd_en_q <= 1'b0;
                        if (last_window) begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        rd_en_q   <= 1'b1;
                        fm_addr_q <= ag_fm_addr;
                        w_addr_q  <= ag_w_addr;
                    end
                end
                DRAIN: begin
                    run_q   <= 1'b0;
                    rd_en_q <= 1'b0;
                    if (wr_ok && last_result) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.fm_addr   = fm_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.pe_en_din = pe_en_q;
    assign bus.pe_en_win = pe_en_q;
    assign bus.out_we    = wr_ok;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = wr_data;
endmodule

// File: tb/tb_conv_pe_seq.sv
// Directed bench for conv_pe_seq: buffer and PE models, per-frame monitor,
// hand-computed expected results and cycle timing.
module tb_conv_pe_seq;
    import conv_pkg::*;

    localparam int DW   = 8;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int NCH  = 3;
    localparam int FAW  = 8;
    localparam int WAW  = 5;
    localparam int OAW  = 6;
    localparam int MACS = MACS_PER_WIN;
    localparam int NW   = 36;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    conv_pe_seq_if #(.DATA_WIDTH(DW), .FM_ADDR_W(FAW), .W_ADDR_W(WAW), .OUT_ADDR_W(OAW)) bus();

    conv_pe_seq #(
        .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .CH(NCH),
        .FM_ADDR_W(FAW), .W_ADDR_W(WAW), .OUT_ADDR_W(OAW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // buffers: one-cycle read latency
    logic [DW-1:0] fm_mem [0:255];
    logic [DW-1:0] w_mem  [0:31];
    logic [DW-1:0] fm_q, w_q;
    always @(posedge clk) begin
        if (bus.rd_en) begin
            fm_q <= fm_mem[bus.fm_addr];
            w_q  <= w_mem[bus.w_addr];
        end
    end

    // PE: MACS accumulate slots, one flush slot, ready the cycle after
    logic [2*DW-1:0] acc, pe_res;
    logic            pe_rdy;
    logic            inj = 1'b0;
    int              pe_cnt;
    assign bus.pe_ready  = pe_rdy | inj;
    assign bus.pe_result = pe_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_cnt <= 0; acc <= '0; pe_rdy <= 1'b0; pe_res <= '0;
        end else begin
            pe_rdy <= 1'b0;
            if (bus.pe_en_din) begin
                if (pe_cnt < MACS) begin
                    acc    <= acc + (2*DW)'(fm_q) * (2*DW)'(w_q);
                    pe_cnt <= pe_cnt + 1;
                end else begin
                    pe_res <= acc; pe_rdy <= 1'b1; acc <= '0; pe_cnt <= 0;
                end
            end
        end
    end

    // checking
    int n_chk  = 0;
    int n_fail = 0;
    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // monitor state (per frame)
    bit              mon_on = 1'b0;
    int              base = 0;
    int              n_wr, addr_err, first_pe, last_pe, first_we, last_we;
    int              done_rel, en_mis, busy_1010;
    logic [2*DW-1:0] res [0:63];
    bit              rd_tr [0:31];
    int              fm_tr [0:31];
    int              w_tr  [0:31];

    always @(negedge clk) begin
        if (mon_on) begin
            automatic int rel = cyc - base;
            if (rel >= 0 && rel < 32) begin
                rd_tr[rel] = bus.rd_en;
                fm_tr[rel] = int'(bus.fm_addr);
                w_tr[rel]  = int'(bus.w_addr);
            end
            if (bus.pe_en_din !== bus.pe_en_win) en_mis++;
            if (bus.pe_en_din) begin
                if (first_pe < 0) first_pe = rel;
                last_pe = rel;
            end
            if (bus.out_we) begin
                if (n_wr == 0) first_we = rel;
                last_we = rel;
                if (int'(bus.out_addr) != n_wr) addr_err++;
                res[bus.out_addr] = bus.out_data;
                n_wr++;
            end
            if (bus.done && done_rel < 0) done_rel = rel;
            if (rel == 1010) busy_1010 = bus.busy;
        end
    end

    // pattern: 0 ones/ones, 1 ones/k, 2 255/255, 3 x+y/ones
    task automatic load(input int pat);
        for (int c = 0; c < NCH; c++)
            for (int y = 0; y < IH; y++)
                for (int x = 0; x < IW; x++)
                    fm_mem[c*64 + y*8 + x] = (pat == 2) ? 8'd255 : (pat == 3) ? 8'(x + y) : 8'd1;
        for (int k = 0; k < 32; k++)
            w_mem[k] = (pat == 1) ? 8'(k) : (pat == 2) ? 8'd255 : 8'd1;
    endtask

    function automatic int exp_val(input int pat, input int a);
        case (pat)
            0: return 27;
            1: return 351;
            2: return 51739;
            default: return 27 * ((a % 6) + (a / 6)) + 54;
        endcase
    endfunction

    task automatic quiet_outputs(input string ph);
        chk({ph, "_busy"},     int'(bus.busy), 0);
        chk({ph, "_done"},     int'(bus.done), 0);
        chk({ph, "_rd_en"},    int'(bus.rd_en), 0);
        chk({ph, "_fm_addr"},  int'(bus.fm_addr), 0);
        chk({ph, "_w_addr"},   int'(bus.w_addr), 0);
        chk({ph, "_pe_en"},    int'(bus.pe_en_din), 0);
        chk({ph, "_pe_en_w"},  int'(bus.pe_en_win), 0);
        chk({ph, "_out_we"},   int'(bus.out_we), 0);
        chk({ph, "_out_addr"}, int'(bus.out_addr), 0);
        chk({ph, "_out_data"}, int'(bus.out_data), 0);
    endtask

    task automatic run_frame(input bit extra_start);
        n_wr = 0; addr_err = 0; first_pe = -1; last_pe = -1; first_we = -1;
        last_we = -1; done_rel = -1; en_mis = 0; busy_1010 = -1;
        for (int i = 0; i < 64; i++) res[i] = '0;
        @(negedge clk);
        base = cyc; mon_on = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.start = extra_start && (cyc - base == 500);
            if (bus.done) break;
        end
        bus.start = 1'b0;
        chk("frame_done_seen", int'(bus.done), 1);
    endtask

    task automatic check_frame(input string tag, input int pat);
        automatic int bad = 0;
        for (int a = 0; a < NW; a++)
            if (int'(res[a]) != exp_val(pat, a)) bad++;
        chk({tag, "_writes"},   n_wr, NW);
        chk({tag, "_addr_seq"}, addr_err, 0);
        chk({tag, "_res0"},     int'(res[0]), exp_val(pat, 0));
        chk({tag, "_bad_data"}, bad, 0);
    endtask

    initial begin
        automatic int fm_exp [0:9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18, 64};
        automatic int rd_hi = 0;
        bus.start = 1'b0;
        load(0);
        #12;
        quiet_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // stray PE ready while idle must not write
        inj = 1'b1;
        #1 chk("idle_ready_no_we", int'(bus.out_we), 0);
        @(negedge clk);
        inj = 1'b0;

        // frame A: ones, with timing and a stray start at cycle 500
        run_frame(1'b1);
        chk("busy_at_done", int'(bus.busy), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_at_done_busy", int'(bus.busy), 0);
        @(negedge clk);
        chk("start_at_done_busy2", int'(bus.busy), 0);
        chk("start_at_done_rd", int'(bus.rd_en), 0);
        check_frame("ones", 0);
        for (int r = 1; r <= 27; r++) if (rd_tr[r]) rd_hi++;
        chk("rd_en_1_27", rd_hi, 27);
        chk("rd_en_28", int'(rd_tr[28]), 0);
        chk("rd_en_29", int'(rd_tr[29]), 1);
        chk("w_addr_hold_28", w_tr[28], 26);
        chk("w_addr_5", w_tr[5], 4);
        for (int i = 0; i < 10; i++) chk($sformatf("fm_addr_slot%0d", i), fm_tr[i+1], fm_exp[i]);
        chk("pe_en_first", first_pe, 2);
        chk("pe_en_last", last_pe, 1009);
        chk("pe_en_din_win", en_mis, 0);
        chk("first_we", first_we, 30);
        chk("last_we", last_we, 1010);
        chk("done_cycle", done_rel, 1011);
        chk("busy_1010", busy_1010, 1);

        load(1);
        run_frame(1'b0);
        check_frame("wk", 1);

        load(2);
        run_frame(1'b0);
        check_frame("max", 2);

        load(3);
        run_frame(1'b0);
        check_frame("ramp", 3);
        chk("ramp_addr7", int'(res[7]), 108);   // window (1,1)
        chk("ramp_addr35", int'(res[35]), 324); // window (5,5)

        // abort mid-frame with reset, then rerun
        load(0);
        @(negedge clk);
        base = cyc; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (499) @(negedge clk);
        chk("abort_busy_before", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1 quiet_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        quiet_outputs("abort2");
        rst_n = 1'b1;
        run_frame(1'b0);
        check_frame("rerun", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
